// File: rtl/ir_pipe_pkg.sv
// ir_pipe_pkg
//   Shared definitions for the instruction-register field pipeline:
//   the $zero register number, default field geometry, and a helper that
//   pulls channel k out of a packed multi-field bus.
package ir_pipe_pkg;

    // Register $zero: never a real hazard source.
    localparam int REG_ZERO   = 0;

    // Classic MIPS ID/EX use: rt and rd, 5 bits each.
    localparam int DEF_WIDTH  = 5;
    localparam int DEF_NUM_CH = 2;

    // Upper bounds for the generic extract helper. Callers zero-extend the
    // bus up to MAX_BUS_W and truncate the result back to their field width.
    localparam int MAX_FIELD_W = 32;
    localparam int MAX_BUS_W   = 1024;

    // Return channel k (w bits wide) of a packed field bus.
    function automatic logic [MAX_FIELD_W-1:0] field_extract(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_FIELD_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1);
        return shifted[MAX_FIELD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ir_field_stage.sv
// ir_field_stage
//   One pipeline stage: valid bit, NUM_CH packed fields and a destination
//   select, with hold (freeze) and bubble (clear) controls.
//
// Ports:
//   clk      - clock, all updates on posedge
//   rst      - synchronous active-high reset, clears the stage
//   hold     - keep current contents, ignore d_*
//   bubble   - load an empty entry (valid/fields/sel = 0); wins over hold
//   d_valid  - incoming valid
//   d_fields - incoming packed fields
//   d_sel    - incoming destination select
//   q_valid  - stored valid
//   q_fields - stored fields
//   q_sel    - stored destination select
module ir_field_stage
    import ir_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    bubble,
    input  logic                    d_valid,
    input  logic [NUM_CH*WIDTH-1:0] d_fields,
    input  logic [SEL_W-1:0]        d_sel,
    output logic                    q_valid,
    output logic [NUM_CH*WIDTH-1:0] q_fields,
    output logic [SEL_W-1:0]        q_sel
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the chain shifts by one.
    // Fields and sel are reset too, so outputs read 0 rather than stale data.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q_valid  <= 1'b0;
            q_fields <= '0;
            q_sel    <= '0;
        end else if (!hold) begin
            // Invalid entries advance with their fields untouched.
            q_valid  <= d_valid;
            q_fields <= d_fields;
            q_sel    <= d_sel;
        end
    end

endmodule

// File: rtl/ir_field_pipe.sv
// ir_field_pipe
//   DEPTH-stage pipeline for instruction register-specifier fields with
//   stall/flush, a per-entry destination select and a per-stage
//   destination-match mask for hazard detection.
//
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset, drops all in-flight entries
//   stall       - freeze every stage
//   flush       - insert a bubble at stage 0 (also applies under stall)
//   in_valid    - incoming entry is a real instruction
//   in_fields   - packed fields, channel k at [k*WIDTH +: WIDTH]
//   in_sel      - which channel is the destination register
//   out_valid   - last-stage valid
//   out_fields  - last-stage fields
//   out_dst     - last-stage selected destination (0 if sel out of range)
//   stage_valid - valid bit per stage, bit 0 = first stage
//   query       - source register to test against in-flight destinations
//   match       - per-stage hit: valid, dst == query, query != $zero
module ir_field_pipe
    import ir_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = 1,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_fields,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_fields,
    output logic [WIDTH-1:0]        out_dst,
    output logic [DEPTH-1:0]        stage_valid,
    input  logic [WIDTH-1:0]        query,
    output logic [DEPTH-1:0]        match
);

    logic [DEPTH-1:0]        st_valid;
    logic [NUM_CH*WIDTH-1:0] st_fields [DEPTH];
    logic [SEL_W-1:0]        st_sel    [DEPTH];

    logic [WIDTH-1:0]        dst       [DEPTH];
    logic [DEPTH-1:0]        sel_ok;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_head
            // Flush only affects the head; it overrides stall there.
            ir_field_stage #(
                .WIDTH  (WIDTH),
                .NUM_CH (NUM_CH),
                .SEL_W  (SEL_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .hold     (stall),
                .bubble   (flush),
                .d_valid  (in_valid),
                .d_fields (in_fields),
                .d_sel    (in_sel),
                .q_valid  (st_valid[s]),
                .q_fields (st_fields[s]),
                .q_sel    (st_sel[s])
            );
        end else begin : g_body
            ir_field_stage #(
                .WIDTH  (WIDTH),
                .NUM_CH (NUM_CH),
                .SEL_W  (SEL_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .hold     (stall),
                .bubble   (1'b0),
                .d_valid  (st_valid[s-1]),
                .d_fields (st_fields[s-1]),
                .d_sel    (st_sel[s-1]),
                .q_valid  (st_valid[s]),
                .q_fields (st_fields[s]),
                .q_sel    (st_sel[s])
            );
        end
    end

    // Destination select and hazard compare per stage. A select past the
    // last channel (NUM_CH not a power of two) yields dst 0 and never hits.
    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            dst[s]    = '0;
            sel_ok[s] = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (st_sel[s] == SEL_W'(k)) begin
                    dst[s]    = WIDTH'(field_extract(MAX_BUS_W'(st_fields[s]), k, WIDTH));
                    sel_ok[s] = 1'b1;
                end
            end
            match[s] = st_valid[s] && sel_ok[s] && (dst[s] == query)
                       && (query != WIDTH'(REG_ZERO));
        end
    end

    assign stage_valid = st_valid;
    assign out_valid   = st_valid[DEPTH-1];
    assign out_fields  = st_fields[DEPTH-1];
    assign out_dst     = dst[DEPTH-1];

endmodule

// File: tb/tb_ir_field_pipe.sv
// tb_ir_field_pipe
//   Two instances: A (WIDTH=5, NUM_CH=2, DEPTH=3) and B (WIDTH=5, NUM_CH=3,
//   DEPTH=2). Directed scenarios use hand-derived constants; the random
//   phase compares both against a queue-based model of the pipeline.
module tb_ir_field_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;

    // Instance A
    logic [9:0] a_in_fields = '0;
    logic       a_in_sel    = '0;
    logic [4:0] a_query     = '0;
    logic       a_out_valid;
    logic [9:0] a_out_fields;
    logic [4:0] a_out_dst;
    logic [2:0] a_stage_valid;
    logic [2:0] a_match;

    // Instance B
    logic [14:0] b_in_fields = '0;
    logic [1:0]  b_in_sel    = '0;
    logic [4:0]  b_query     = '0;
    logic        b_out_valid;
    logic [14:0] b_out_fields;
    logic [4:0]  b_out_dst;
    logic [1:0]  b_stage_valid;
    logic [1:0]  b_match;

    int n_checks = 0;
    int n_fail   = 0;

    ir_field_pipe #(.WIDTH(5), .NUM_CH(2), .DEPTH(3)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_fields(a_in_fields), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_fields(a_out_fields), .out_dst(a_out_dst),
        .stage_valid(a_stage_valid), .query(a_query), .match(a_match)
    );

    ir_field_pipe #(.WIDTH(5), .NUM_CH(3), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_fields(b_in_fields), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_fields(b_out_fields), .out_dst(b_out_dst),
        .stage_valid(b_stage_valid), .query(b_query), .match(b_match)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [14:0] f;
        logic [1:0]  s;
    } entry_t;

    // Index 0 = first stage, last index = output stage.
    entry_t qa[$];
    entry_t qb[$];

    function automatic logic [4:0] exp_dst(entry_t e, int nch);
        if (int'(e.s) >= nch) return 5'd0;
        return e.f[int'(e.s)*5 +: 5];
    endfunction

    function automatic logic exp_hit(entry_t e, int nch, logic [4:0] q);
        return e.v && (int'(e.s) < nch) && (exp_dst(e, nch) == q) && (q != 5'd0);
    endfunction

    task automatic model_update();
        entry_t ea, eb;
        ea = '0; eb = '0;
        ea.v = in_valid; ea.f = {5'd0, a_in_fields}; ea.s = {1'b0, a_in_sel};
        eb.v = in_valid; eb.f = b_in_fields;         eb.s = b_in_sel;
        if (rst) begin
            for (int i = 0; i < qa.size(); i++) qa[i] = '0;
            for (int i = 0; i < qb.size(); i++) qb[i] = '0;
        end else if (stall) begin
            if (flush) begin
                qa[0] = '0;
                qb[0] = '0;
            end
        end else begin
            if (flush) begin
                ea = '0;
                eb = '0;
            end
            qa.push_front(ea); void'(qa.pop_back());
            qb.push_front(eb); void'(qb.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        a_in_fields = 10'h3ff; a_in_sel = 1'b1;
        b_in_fields = 15'h7fff; b_in_sel = 2'd2;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({a_out_valid, a_out_fields, a_out_dst, a_stage_valid} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_a cycle %0d: got v=%0b f=%h d=%0d sv=%b want all 0",
                         c, a_out_valid, a_out_fields, a_out_dst, a_stage_valid);
            end
            n_checks++;
            if ({b_out_valid, b_out_fields, b_out_dst, b_stage_valid} !== 23'd0) begin
                n_fail++;
                $display("FAIL reset_b cycle %0d: got v=%0b f=%h d=%0d sv=%b want all 0",
                         c, b_out_valid, b_out_fields, b_out_dst, b_stage_valid);
            end
        end
        rst = 1'b0; in_valid = 1'b0; a_in_fields = '0; b_in_fields = '0;
        a_in_sel = '0; b_in_sel = '0;
        tick();
        n_checks++;
        if ({a_out_valid, a_out_dst, a_stage_valid} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_after: got v=%0b d=%0d sv=%b want 0", a_out_valid, a_out_dst, a_stage_valid);
        end
    endtask

    task automatic test_latency();
        for (int pass = 0; pass < 2; pass++) begin
            in_valid = 1'b1; a_in_fields = {5'd9, 5'd8}; a_in_sel = (pass == 0);
            for (int c = 1; c <= 3; c++) begin
                tick();
                in_valid = 1'b0; a_in_fields = '0; a_in_sel = 1'b0;
                if (c < 3) begin
                    n_checks++;
                    if (a_out_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL latency_early cycle %0d: got out_valid=%0b want 0", c, a_out_valid);
                    end
                end
            end
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_dst !== ((pass == 0) ? 5'd9 : 5'd8)
                || a_out_fields !== {5'd9, 5'd8}) begin
                n_fail++;
                $display("FAIL latency_sel%0d: got v=%0b dst=%0d f=%h want v=1 dst=%0d f=%h",
                         (pass == 0), a_out_valid, a_out_dst, a_out_fields,
                         (pass == 0) ? 9 : 8, {5'd9, 5'd8});
            end
        end
    endtask

    task automatic test_stall();
        a_in_sel = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            in_valid = 1'b1; a_in_fields = 10'(e);
            tick();
        end
        n_checks++;
        if (a_out_fields !== 10'd1 || a_stage_valid !== 3'b111) begin
            n_fail++;
            $display("FAIL stall_fill: got f=%0d sv=%b want f=1 sv=111", a_out_fields, a_stage_valid);
        end
        stall = 1'b1; a_in_fields = 10'd31; a_query = 5'd2;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (a_out_fields !== 10'd1 || a_stage_valid !== 3'b111 || a_match !== 3'b010) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got f=%0d sv=%b m=%b want f=1 sv=111 m=010",
                         c, a_out_fields, a_stage_valid, a_match);
            end
        end
        stall = 1'b0; in_valid = 1'b0; a_in_fields = '0; a_query = '0;
        for (int e = 2; e <= 4; e++) begin
            tick();
            n_checks++;
            if (a_out_valid !== (e <= 3) || a_out_fields !== ((e <= 3) ? 10'(e) : 10'd0)) begin
                n_fail++;
                $display("FAIL stall_resume step %0d: got v=%0b f=%0d want v=%0b f=%0d",
                         e, a_out_valid, a_out_fields, (e <= 3), (e <= 3) ? e : 0);
            end
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; a_in_sel = 1'b0;
        a_in_fields = 10'd4; tick();
        a_in_fields = 10'd5; flush = 1'b1; tick();
        a_query = 5'd4;
        #1;
        n_checks++;
        if (a_stage_valid !== 3'b010 || a_match !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_head: got sv=%b m=%b want sv=010 m=010", a_stage_valid, a_match);
        end
        a_in_fields = 10'd6; flush = 1'b0; tick();
        n_checks++;
        if (a_stage_valid !== 3'b101 || a_out_fields !== 10'd4) begin
            n_fail++;
            $display("FAIL flush_advance: got sv=%b f=%0d want sv=101 f=4", a_stage_valid, a_out_fields);
        end
        a_in_fields = 10'd7; stall = 1'b1; flush = 1'b1; tick();
        n_checks++;
        if (a_stage_valid !== 3'b100 || a_out_fields !== 10'd4 || a_match !== 3'b100) begin
            n_fail++;
            $display("FAIL flush_under_stall: got sv=%b f=%0d m=%b want sv=100 f=4 m=100",
                     a_stage_valid, a_out_fields, a_match);
        end
        stall = 1'b0; flush = 1'b0; a_query = '0;
    endtask

    task automatic test_match();
        in_valid = 1'b1; a_in_fields = {5'd0, 5'd0}; a_in_sel = 1'b0; tick();
        in_valid = 1'b1; a_in_fields = {5'd9, 5'd3}; a_in_sel = 1'b1; tick();
        in_valid = 1'b0; a_in_fields = {5'd9, 5'd9}; a_in_sel = 1'b1; tick();
        in_valid = 1'b0; a_in_fields = '0; a_in_sel = 1'b0;
        a_query = 5'd9; #1;
        n_checks++;
        if (a_match !== 3'b010) begin
            n_fail++;
            $display("FAIL match_q9: got %b want 010", a_match);
        end
        a_query = 5'd0; #1;
        n_checks++;
        if (a_match !== 3'b000 || a_out_valid !== 1'b1 || a_out_dst !== 5'd0) begin
            n_fail++;
            $display("FAIL match_zero: got m=%b v=%0b dst=%0d want m=000 v=1 dst=0",
                     a_match, a_out_valid, a_out_dst);
        end
        a_query = 5'd3; #1;
        n_checks++;
        if (a_match !== 3'b000) begin
            n_fail++;
            $display("FAIL match_unselected: got %b want 000", a_match);
        end
        a_query = '0;
    endtask

    task automatic test_odd_channels();
        in_valid = 1'b1; b_in_fields = {5'd7, 5'd6, 5'd5}; b_in_sel = 2'd3; tick();
        b_in_sel = 2'd2; tick();
        in_valid = 1'b0; b_in_fields = '0; b_in_sel = '0;
        b_query = 5'd7; #1;
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_dst !== 5'd0 || b_match !== 2'b01) begin
            n_fail++;
            $display("FAIL odd_sel3: got v=%0b dst=%0d m=%b want v=1 dst=0 m=01",
                     b_out_valid, b_out_dst, b_match);
        end
        tick();
        n_checks++;
        if (b_out_dst !== 5'd7 || b_match !== 2'b10) begin
            n_fail++;
            $display("FAIL odd_sel2: got dst=%0d m=%b want dst=7 m=10", b_out_dst, b_match);
        end
        b_query = '0;
    endtask

    task automatic test_random();
        logic [2:0] e_sv_a, e_m_a;
        logic [1:0] e_sv_b, e_m_b;
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 39) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            in_valid    = 1'($urandom_range(0, 1));
            a_in_fields = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            a_in_sel    = 1'($urandom_range(0, 1));
            b_in_fields = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            b_in_sel    = 2'($urandom_range(0, 3));
            a_query     = 5'($urandom_range(0, 3));
            b_query     = 5'($urandom_range(0, 3));
            tick();
            for (int i = 0; i < 3; i++) begin
                e_sv_a[i] = qa[i].v;
                e_m_a[i]  = exp_hit(qa[i], 2, a_query);
            end
            for (int i = 0; i < 2; i++) begin
                e_sv_b[i] = qb[i].v;
                e_m_b[i]  = exp_hit(qb[i], 3, b_query);
            end
            n_checks++;
            if (a_out_valid !== qa[2].v || a_out_fields !== qa[2].f[9:0]
                || a_out_dst !== exp_dst(qa[2], 2) || a_stage_valid !== e_sv_a || a_match !== e_m_a) begin
                n_fail++;
                $display("FAIL random_a cycle %0d: got v=%0b f=%h d=%0d sv=%b m=%b want v=%0b f=%h d=%0d sv=%b m=%b",
                         c, a_out_valid, a_out_fields, a_out_dst, a_stage_valid, a_match,
                         qa[2].v, qa[2].f[9:0], exp_dst(qa[2], 2), e_sv_a, e_m_a);
            end
            n_checks++;
            if (b_out_valid !== qb[1].v || b_out_fields !== qb[1].f
                || b_out_dst !== exp_dst(qb[1], 3) || b_stage_valid !== e_sv_b || b_match !== e_m_b) begin
                n_fail++;
                $display("FAIL random_b cycle %0d: got v=%0b f=%h d=%0d sv=%b m=%b want v=%0b f=%h d=%0d sv=%b m=%b",
                         c, b_out_valid, b_out_fields, b_out_dst, b_stage_valid, b_match,
                         qb[1].v, qb[1].f, exp_dst(qb[1], 3), e_sv_b, e_m_b);
            end
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) qa.push_back('0);
        for (int i = 0; i < 2; i++) qb.push_back('0);
        #2;
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_match();
        test_odd_channels();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
